// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared constants and helpers for the 4-slot TDM demultiplexer
//  Revision    : 1.0  initial release
// ============================================================================
package tdm_pkg;

    localparam int SLOT_COUNT = 4;
    localparam int SLOT_W     = 2;
    localparam int DROP_W     = 8;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Bit-reverse a frame word so slot 0 ends up in the top bit.
    function automatic logic [SLOT_COUNT-1:0] reverse_word(input logic [SLOT_COUNT-1:0] w);
        logic [SLOT_COUNT-1:0] r;
        r = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            r[i] = w[SLOT_COUNT-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_demux4_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux4_if
//  Description : Serial input and frame-output bundle of the TDM demultiplexer
//  Revision    : 1.0  initial release
// ============================================================================
interface tdm_demux4_if;
    import tdm_pkg::*;

    logic                  din;
    logic                  din_valid;
    logic                  sync;
    logic [SLOT_COUNT-1:0] out;
    logic                  out_valid;
    logic [SLOT_W-1:0]     slot;
    logic [SLOT_COUNT-1:0] slot_sel;
    logic                  sync_err;
    logic [DROP_W-1:0]     drop_cnt;

    // Serial source side: drives the bit stream, observes the frame outputs.
    modport master (
        output din, din_valid, sync,
        input  out, out_valid, slot, slot_sel, sync_err, drop_cnt
    );

    // Demultiplexer side.
    modport slave (
        input  din, din_valid, sync,
        output out, out_valid, slot, slot_sel, sync_err, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tdm_demux4_slot_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : slot_decoder
//  Description : Binary slot index to one-hot select, gated by an enable
//  Revision    : 1.0  initial release
// ============================================================================
module slot_decoder
    import tdm_pkg::*;
(
    input  wire logic [SLOT_W-1:0]     idx,
    input  wire logic                  en,
    output logic      [SLOT_COUNT-1:0] onehot
);

    genvar i;
    // One comparator per output bit.
    generate
        for (i = 0; i < SLOT_COUNT; i++) begin : g_bit
            assign onehot[i] = en & (idx == SLOT_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux4
//  Description : 4-slot time-division demultiplexer. Collects serial bits into
//                a staging register and publishes each completed 4-bit frame,
//                with sync-driven realignment and drop counting.
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    tdm_demux4_if.slave  bus
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_COUNT - 1);

    logic [SLOT_COUNT-2:0] staging;
    logic [SLOT_W-1:0]     slot;
    logic [SLOT_COUNT-1:0] out;
    logic                  out_valid;
    logic                  sync_err;
    logic [DROP_W-1:0]     drop_cnt;

    logic [SLOT_COUNT-1:0] raw_word;
    logic [SLOT_COUNT-1:0] frame_word;

    // The completing bit joins the frame straight from din, so no dead cycle.
    assign raw_word = {bus.din, staging};

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign frame_word = raw_word;
        end else begin : g_msb_first
            assign frame_word = reverse_word(raw_word);
        end
    endgenerate

    // Slot tracking, staging capture, frame publication and sync handling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging   <= '0;
            slot      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (bus.sync) begin
                // Sync wins over frame completion: a partial frame is dropped.
                staging <= '0;
                if (bus.din_valid) begin
                    staging[0] <= bus.din;
                    slot       <= SLOT_W'(1);
                end else begin
                    slot <= '0;
                end
                if (slot != '0) begin
                    sync_err <= 1'b1;
                    if (drop_cnt != DROP_MAX) begin
                        drop_cnt <= drop_cnt + DROP_W'(1);
                    end
                end
            end else if (bus.din_valid) begin
                case (slot)
                    2'd0:    staging[0] <= bus.din;
                    2'd1:    staging[1] <= bus.din;
                    2'd2:    staging[2] <= bus.din;
                    default: ;
                endcase
                slot <= slot + SLOT_W'(1);
                if (slot == LAST_SLOT) begin
                    out       <= frame_word;
                    out_valid <= 1'b1;
                end
            end
        end
    end

    slot_decoder u_slot_decoder (
        .idx    (slot),
        .en     (1'b1),
        .onehot (bus.slot_sel)
    );

    assign bus.out       = out;
    assign bus.out_valid = out_valid;
    assign bus.slot      = slot;
    assign bus.sync_err  = sync_err;
    assign bus.drop_cnt  = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux4
//  Description : Directed self-checking bench for tdm_demux4 (both bit orders)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_demux4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   pulses;

    tdm_demux4_if bus0 ();
    tdm_demux4_if bus1 ();

    // Second instance (slot 0 in the top bit) sees the same stream.
    assign bus1.din       = bus0.din;
    assign bus1.din_valid = bus0.din_valid;
    assign bus1.sync      = bus0.sync;

    tdm_demux4 #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    tdm_demux4 #(.LSB_FIRST(1'b0)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input vector, clock it in, settle 1 time unit past the edge.
    task automatic cyc(input logic d, input logic v, input logic s);
        bus0.din       = d;
        bus0.din_valid = v;
        bus0.sync      = s;
        @(posedge clk);
        #1;
        if (bus0.out_valid === 1'b1) pulses++;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        pulses = 0;
        reset          = 1'b1;
        bus0.din       = 1'b0;
        bus0.din_valid = 1'b0;
        bus0.sync      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_out",       32'(bus0.out),       32'h0);
        chk("rst_out_valid", 32'(bus0.out_valid), 32'h0);
        chk("rst_slot",      32'(bus0.slot),      32'h0);
        chk("rst_slot_sel",  32'(bus0.slot_sel),  32'h1);
        chk("rst_sync_err",  32'(bus0.sync_err),  32'h0);
        chk("rst_drop_cnt",  32'(bus0.drop_cnt),  32'h0);
        reset = 1'b0;

        // Nominal frame 0,1,0,1
        cyc(1'b0, 1'b1, 1'b0);
        chk("nom_slot1",     32'(bus0.slot),      32'h1);
        chk("nom_sel1",      32'(bus0.slot_sel),  32'h2);
        chk("nom_nov1",      32'(bus0.out_valid), 32'h0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("nom_slot3",     32'(bus0.slot),      32'h3);
        chk("nom_sel3",      32'(bus0.slot_sel),  32'h8);
        cyc(1'b1, 1'b1, 1'b0);
        chk("nom_out",       32'(bus0.out),       32'hA);
        chk("nom_out_valid", 32'(bus0.out_valid), 32'h1);
        chk("nom_msb_out",   32'(bus1.out),       32'h5);
        chk("nom_slot_wrap", 32'(bus0.slot),      32'h0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("nom_pulse_end", 32'(bus0.out_valid), 32'h0);
        chk("nom_out_hold",  32'(bus0.out),       32'hA);

        // Back-to-back frames 1010 then 0101 with mid-frame gaps
        pulses = 0;
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) cyc(1'b1, 1'b0, 1'b0);
        chk("gap_slot_frozen", 32'(bus0.slot),    32'h2);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("b2b_out1",      32'(bus0.out),       32'hA);
        chk("b2b_valid1",    32'(bus0.out_valid), 32'h1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("b2b_next_slot", 32'(bus0.slot),      32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, 1'b0);
        chk("gap2_slot",     32'(bus0.slot),      32'h2);
        chk("gap2_out_hold", 32'(bus0.out),       32'hA);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("b2b_out2",      32'(bus0.out),       32'h5);
        chk("b2b_msb_out2",  32'(bus1.out),       32'hA);
        cyc(1'b0, 1'b0, 1'b0);
        chk("b2b_pulses",    32'(pulses),         32'd2);

        // Mid-frame sync carrying a valid bit
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("sync_err_pulse", 32'(bus0.sync_err), 32'h1);
        chk("sync_drop1",    32'(bus0.drop_cnt),  32'h1);
        chk("sync_slot1",    32'(bus0.slot),      32'h1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("sync_err_end",  32'(bus0.sync_err),  32'h0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("sync_out",      32'(bus0.out),       32'hF);
        chk("sync_out_valid", 32'(bus0.out_valid), 32'h1);

        // Sync at slot 0 is not an error
        cyc(1'b0, 1'b0, 1'b1);
        chk("sync0_no_err",  32'(bus0.sync_err),  32'h0);
        chk("sync0_drop",    32'(bus0.drop_cnt),  32'h1);
        chk("sync0_slot",    32'(bus0.slot),      32'h0);

        // Sync at slot 3 beats frame completion
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("sync3_no_valid", 32'(bus0.out_valid), 32'h0);
        chk("sync3_err",     32'(bus0.sync_err),  32'h1);
        chk("sync3_drop",    32'(bus0.drop_cnt),  32'h2);
        chk("sync3_slot",    32'(bus0.slot),      32'h1);
        chk("sync3_out_hold", 32'(bus0.out),      32'hF);
        cyc(1'b0, 1'b0, 1'b1);
        chk("sync3_realign", 32'(bus0.drop_cnt),  32'h3);

        // drop_cnt saturation
        pulses = 0;
        for (int r = 0; r < 300; r++) begin
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b1);
        end
        chk("sat_drop_cnt",  32'(bus0.drop_cnt),  32'd255);
        chk("sat_no_pulses", 32'(pulses),         32'd0);

        // Reset mid-frame
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("arst_out",      32'(bus0.out),       32'h0);
        chk("arst_slot",     32'(bus0.slot),      32'h0);
        chk("arst_sel",      32'(bus0.slot_sel),  32'h1);
        chk("arst_drop",     32'(bus0.drop_cnt),  32'h0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("arst_ignore_in", 32'(bus0.slot),     32'h0);
        chk("arst_no_err",   32'(bus0.sync_err),  32'h0);
        reset = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("post_rst_out",  32'(bus0.out),       32'h1);
        chk("post_rst_msb",  32'(bus1.out),       32'h8);
        chk("post_rst_valid", 32'(bus0.out_valid), 32'h1);
        chk("post_rst_drop", 32'(bus0.drop_cnt),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
